// File: rtl/rv_pkg.sv
// Shared encodings for the memory stage: result-select codes, load/store
// width codes and the bus FSM state type.
package rv_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/rv_mem_align.sv
// Byte-lane steering for the data bus: byte enables, replicated store data
// and misalignment detection from the low address bits and funct3.
module rv_mem_align
  import rv_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  // Loads always fetch the whole word; the write stage extracts the lane.
  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_funct3)
      LS_B, LS_BU: begin
        if (i_store) begin
          o_be    = 4'b0001 << i_addr;
          o_wdata = {4{i_wdata[7:0]}};
        end
      end
      LS_H, LS_HU: begin
        o_misaligned = i_addr[0];
        if (i_store) begin
          o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
      end
      LS_W: o_misaligned = |i_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_memory.sv
// Memory-access pipeline stage: registers execute results, runs the data bus
// req/ack cycle, stalls while it is outstanding and flags faults.
module rv_memory
  import rv_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_flush,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_wdata,
  input  logic        i_mem_write,
  input  logic        i_reg_write,
  input  logic [4:0]  i_rd,
  input  logic [1:0]  i_res_src,
  input  logic [29:0] i_pc_p4,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_alu_result,
  output logic        o_reg_write,
  output logic [4:0]  o_rd,
  output logic [1:0]  o_res_src,
  output logic [29:0] o_pc_p4,
  output logic [2:0]  o_funct3,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [29:0] o_dbus_addr,
  output logic [3:0]  o_dbus_be,
  output logic [31:0] o_dbus_wdata,
  input  logic        i_dbus_ack,
  input  logic [31:0] i_dbus_rdata,
  output mem_state_t  o_dbg_state
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic             TO_EN  = (TIMEOUT != 0);

  logic        r_valid;
  logic [31:0] r_alu_result;
  logic [31:0] r_wdata;
  logic        r_mem_write;
  logic        r_reg_write;
  logic [4:0]  r_rd;
  logic [1:0]  r_res_src;
  logic [29:0] r_pc_p4;
  logic [2:0]  r_funct3;
  logic [31:0] r_rdata;
  logic [CNT_W-1:0] r_cnt;
  mem_state_t  r_state;
  mem_state_t  w_state_nxt;

  logic        w_memop;
  logic        w_align_mis;
  logic        w_mis;
  logic        w_go;
  logic        w_req;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  rv_mem_align u_align (
    .i_addr       (r_alu_result[1:0]),
    .i_funct3     (r_funct3),
    .i_store      (r_mem_write),
    .i_wdata      (r_wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_align_mis)
  );

  assign w_memop   = r_valid & (r_mem_write | (r_res_src == RES_MEM));
  assign w_mis     = w_memop & w_align_mis;
  assign w_go      = w_memop & ~w_align_mis;
  assign w_timeout = (r_state == WAIT) & ~i_dbus_ack & TO_EN & (r_cnt == TO_CNT);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid      <= 1'b0;
      r_alu_result <= '0;
      r_wdata      <= '0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_res_src    <= '0;
      r_pc_p4      <= '0;
      r_funct3     <= '0;
    end else if (!o_stall) begin
      r_valid      <= i_valid & ~i_flush;
      r_alu_result <= i_alu_result;
      r_wdata      <= i_wdata;
      r_mem_write  <= i_mem_write;
      r_reg_write  <= i_reg_write;
      r_rd         <= i_rd;
      r_res_src    <= i_res_src;
      r_pc_p4      <= i_pc_p4;
      r_funct3     <= i_funct3;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Bus handshake: o_dbus_req rises when an aligned memop sits in the stage
  // and stays high with addr/be/we/wdata frozen until the cycle i_dbus_ack is
  // seen (possibly the request cycle itself) or the wait times out.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      IDLE: begin
        w_req = w_go;
        if (w_go && !i_dbus_ack) w_state_nxt = WAIT;
      end
      WAIT: begin
        w_req = 1'b1;
        if (i_dbus_ack || w_timeout) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                r_cnt <= '0;
    else if (r_state == IDLE)   r_cnt <= '0;
    else if (r_cnt != '1)       r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                  r_rdata <= '0;
    else if (w_req && i_dbus_ack) r_rdata <= i_dbus_rdata;
  end

  assign o_stall      = w_go & ~i_dbus_ack & ~w_timeout;
  assign o_reg_write  = r_valid & r_reg_write & ~o_stall & ~w_mis & ~w_timeout;
  assign o_misaligned = w_mis;
  assign o_bus_err    = w_timeout;
  assign o_alu_result = r_alu_result;
  assign o_rd         = r_rd;
  assign o_res_src    = r_res_src;
  assign o_pc_p4      = r_pc_p4;
  assign o_funct3     = r_funct3;
  assign o_rdata      = r_rdata;
  assign o_dbus_req   = w_req;
  assign o_dbus_we    = w_req & r_mem_write;
  assign o_dbus_addr  = r_alu_result[31:2];
  assign o_dbus_be    = w_req ? w_be : 4'b0000;
  assign o_dbus_wdata = w_req ? w_wdata : 32'h0;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_rv_memory.sv
// Directed bench for rv_memory: ALU pass-through, loads/stores with various
// ack timing, misalignment, timeout and reset during a bus wait.
module tb_rv_memory;
  import rv_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        i_flush;
  logic [31:0] i_alu_result;
  logic [31:0] i_wdata;
  logic        i_mem_write;
  logic        i_reg_write;
  logic [4:0]  i_rd;
  logic [1:0]  i_res_src;
  logic [29:0] i_pc_p4;
  logic [2:0]  i_funct3;
  logic [31:0] o_alu_result;
  logic        o_reg_write;
  logic [4:0]  o_rd;
  logic [1:0]  o_res_src;
  logic [29:0] o_pc_p4;
  logic [2:0]  o_funct3;
  logic [31:0] o_rdata;
  logic        o_stall;
  logic        o_misaligned;
  logic        o_bus_err;
  logic        o_dbus_req;
  logic        o_dbus_we;
  logic [29:0] o_dbus_addr;
  logic [3:0]  o_dbus_be;
  logic [31:0] o_dbus_wdata;
  logic        i_dbus_ack;
  logic [31:0] i_dbus_rdata;
  mem_state_t  o_dbg_state;

  int total = 0;
  int bad   = 0;

  rv_memory #(.TIMEOUT(4), .CNT_W(8)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_valid),
    .i_flush      (i_flush),
    .i_alu_result (i_alu_result),
    .i_wdata      (i_wdata),
    .i_mem_write  (i_mem_write),
    .i_reg_write  (i_reg_write),
    .i_rd         (i_rd),
    .i_res_src    (i_res_src),
    .i_pc_p4      (i_pc_p4),
    .i_funct3     (i_funct3),
    .o_alu_result (o_alu_result),
    .o_reg_write  (o_reg_write),
    .o_rd         (o_rd),
    .o_res_src    (o_res_src),
    .o_pc_p4      (o_pc_p4),
    .o_funct3     (o_funct3),
    .o_rdata      (o_rdata),
    .o_stall      (o_stall),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err),
    .o_dbus_req   (o_dbus_req),
    .o_dbus_we    (o_dbus_we),
    .o_dbus_addr  (o_dbus_addr),
    .o_dbus_be    (o_dbus_be),
    .o_dbus_wdata (o_dbus_wdata),
    .i_dbus_ack   (i_dbus_ack),
    .i_dbus_rdata (i_dbus_rdata),
    .o_dbg_state  (o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic mw, input logic rw, input logic [4:0] rd,
                       input logic [1:0] rs, input logic [2:0] f3);
    i_valid      = v;
    i_alu_result = alu;
    i_wdata      = wd;
    i_mem_write  = mw;
    i_reg_write  = rw;
    i_rd         = rd;
    i_res_src    = rs;
    i_funct3     = f3;
    i_pc_p4      = 30'h1234;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, RES_ALU, LS_B);
  endtask

  initial begin
    i_reset      = 1'b1;
    i_flush      = 1'b0;
    i_dbus_ack   = 1'b0;
    i_dbus_rdata = 32'h0;
    bubble();
    tick();
    tick();
    chk("rst_reg_write", 32'(o_reg_write), 32'h0);
    chk("rst_req",       32'(o_dbus_req),  32'h0);
    chk("rst_stall",     32'(o_stall),     32'h0);
    chk("rst_alu",       o_alu_result,     32'h0);
    chk("rst_rdata",     o_rdata,          32'h0);
    chk("rst_be",        32'(o_dbus_be),   32'h0);
    chk("rst_state",     32'(o_dbg_state == WAIT), 32'h0);
    i_reset = 1'b0;

    // ADD x5: visible one cycle later, no stall
    drive(1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 5'd5, RES_ALU, LS_B);
    tick();
    bubble();
    #1;
    chk("add_reg_write", 32'(o_reg_write), 32'h1);
    chk("add_rd",        32'(o_rd),        32'd5);
    chk("add_alu",       o_alu_result,     32'h10);
    chk("add_stall",     32'(o_stall),     32'h0);
    chk("add_req",       32'(o_dbus_req),  32'h0);

    // LW 0x100 acked in the request cycle
    drive(1'b1, 32'h100, 32'h0, 1'b0, 1'b1, 5'd6, RES_MEM, LS_W);
    tick();
    bubble();
    i_dbus_ack   = 1'b1;
    i_dbus_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_req",       32'(o_dbus_req),  32'h1);
    chk("lw_we",        32'(o_dbus_we),   32'h0);
    chk("lw_addr",      32'(o_dbus_addr), 32'h40);
    chk("lw_be",        32'(o_dbus_be),   32'hF);
    chk("lw_stall",     32'(o_stall),     32'h0);
    chk("lw_reg_write", 32'(o_reg_write), 32'h1);
    tick();
    i_dbus_ack   = 1'b0;
    i_dbus_rdata = 32'h0;
    #1;
    chk("lw_req_drop", 32'(o_dbus_req), 32'h0);
    chk("lw_rdata",    o_rdata,         32'hDEADBEEF);

    // SB 0x103, ack after three stall cycles; flushed instruction at completion
    drive(1'b1, 32'h103, 32'h55, 1'b1, 1'b0, 5'd0, RES_ALU, LS_B);
    tick();
    bubble();
    #1;
    chk("sb_req",       32'(o_dbus_req),   32'h1);
    chk("sb_we",        32'(o_dbus_we),    32'h1);
    chk("sb_be",        32'(o_dbus_be),    32'h8);
    chk("sb_wdata",     o_dbus_wdata,      32'h55555555);
    chk("sb_addr",      32'(o_dbus_addr),  32'h40);
    chk("sb_stall1",    32'(o_stall),      32'h1);
    chk("sb_reg_write", 32'(o_reg_write),  32'h0);
    tick();
    chk("sb_stall2",    32'(o_stall),      32'h1);
    chk("sb_state",     32'(o_dbg_state == WAIT), 32'h1);
    chk("sb_be_hold",   32'(o_dbus_be),    32'h8);
    tick();
    chk("sb_stall3",    32'(o_stall),      32'h1);
    tick();
    drive(1'b1, 32'h44, 32'h0, 1'b0, 1'b1, 5'd7, RES_ALU, LS_B);
    i_flush    = 1'b1;
    i_dbus_ack = 1'b1;
    #1;
    chk("sb_done_stall", 32'(o_stall),     32'h0);
    chk("sb_done_req",   32'(o_dbus_req),  32'h1);
    chk("sb_done_rw",    32'(o_reg_write), 32'h0);
    tick();
    i_flush    = 1'b0;
    i_dbus_ack = 1'b0;
    bubble();
    #1;
    chk("flush_req", 32'(o_dbus_req),  32'h0);
    chk("flush_rw",  32'(o_reg_write), 32'h0);
    chk("flush_rd",  32'(o_rd),        32'd7);
    chk("flush_alu", o_alu_result,     32'h44);

    // LH 0x101: misaligned, no bus cycle
    drive(1'b1, 32'h101, 32'h0, 1'b0, 1'b1, 5'd8, RES_MEM, LS_H);
    tick();
    bubble();
    #1;
    chk("lh_mis",   32'(o_misaligned), 32'h1);
    chk("lh_req",   32'(o_dbus_req),   32'h0);
    chk("lh_stall", 32'(o_stall),      32'h0);
    chk("lh_rw",    32'(o_reg_write),  32'h0);
    tick();
    chk("lh_mis_pulse", 32'(o_misaligned), 32'h0);

    // SH 0x102 acked immediately: upper half lanes
    drive(1'b1, 32'h102, 32'h1234ABCD, 1'b1, 1'b0, 5'd0, RES_ALU, LS_H);
    tick();
    bubble();
    i_dbus_ack = 1'b1;
    #1;
    chk("sh_be",    32'(o_dbus_be), 32'hC);
    chk("sh_wdata", o_dbus_wdata,   32'hABCDABCD);
    chk("sh_stall", 32'(o_stall),   32'h0);
    chk("sh_mis",   32'(o_misaligned), 32'h0);
    tick();
    i_dbus_ack = 1'b0;

    // LW 0x200 with no ack: 5 stall cycles, then bus error
    drive(1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 5'd9, RES_MEM, LS_W);
    tick();
    drive(1'b1, 32'h33, 32'h0, 1'b0, 1'b1, 5'd10, RES_ALU, LS_B);
    #1;
    chk("to_req", 32'(o_dbus_req), 32'h1);
    chk("to_stall_0", 32'(o_stall), 32'h1);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("to_stall_%0d", i), 32'(o_stall), 32'h1);
      chk($sformatf("to_noerr_%0d", i), 32'(o_bus_err), 32'h0);
    end
    tick();
    chk("to_err",   32'(o_bus_err),   32'h1);
    chk("to_stall", 32'(o_stall),     32'h0);
    chk("to_rw",    32'(o_reg_write), 32'h0);
    tick();
    bubble();
    #1;
    chk("to_err_pulse", 32'(o_bus_err),   32'h0);
    chk("to_req_drop",  32'(o_dbus_req),  32'h0);
    chk("to_next_rw",   32'(o_reg_write), 32'h1);
    chk("to_next_rd",   32'(o_rd),        32'd10);
    chk("to_next_alu",  o_alu_result,     32'h33);

    // Reset raised while waiting on the bus
    drive(1'b1, 32'h300, 32'h0, 1'b0, 1'b1, 5'd11, RES_MEM, LS_W);
    tick();
    bubble();
    tick();
    chk("rw_state_wait", 32'(o_dbg_state == WAIT), 32'h1);
    i_reset = 1'b1;
    #1;
    chk("rw_req",   32'(o_dbus_req),  32'h0);
    chk("rw_stall", 32'(o_stall),     32'h0);
    chk("rw_rw",    32'(o_reg_write), 32'h0);
    chk("rw_rdata", o_rdata,          32'h0);
    tick();
    i_reset = 1'b0;
    tick();
    chk("rw_after_state", 32'(o_dbg_state == WAIT), 32'h0);
    chk("rw_after_rw",    32'(o_reg_write), 32'h0);
    chk("rw_after_req",   32'(o_dbus_req),  32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
